// File: rtl/inevt_pkg.sv
// Shared register map, bit positions and helpers for the inevt_wb input-event peripheral.
package inevt_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_CHEN = 2'd2;
    localparam logic [1:0] REG_IRQ  = 2'd3;

    localparam int unsigned EMPTY    = 31;
    localparam int unsigned FULL     = 30;
    localparam int unsigned FLUSH    = 31;
    localparam int unsigned LVL_LSB  = 16;
    localparam int unsigned CHID_LSB = 16;
    localparam int unsigned CHID_W   = 3;

    // Level field is 8 bits wide; a 256-deep FIFO reports 255 when completely full.
    function automatic logic [7:0] sat_level(input logic [8:0] lvl);
        return (lvl > 9'd255) ? 8'hFF : lvl[7:0];
    endfunction

endpackage

// File: rtl/inevt_fifo.sv
// Synchronous-RAM FIFO with first-word fall-through head, flush and occupancy level.
module inevt_fifo #(
    parameter int unsigned W     = 11,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [W-1:0]  wdata,
    input  logic          rd,
    input  logic          flush,
    output logic [W-1:0]  rdata,
    output logic [LW-1:0] level,
    output logic          empty,
    output logic          full
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [LW-1:0] level_q;
    logic          do_wr, do_rd;

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign do_wr = wr & ~full & ~flush;
    assign do_rd = rd & ~empty & ~flush;
    assign rdata = mem[rptr_q];
    assign level = level_q;

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (do_rd) rptr_q <= rptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/inevt_wb.sv
// Multi-channel input-event capture on Wishbone: pending regs, round-robin arbiter, tagged FIFO.
// Optional level interrupt and IRQ_CFG register are built only when INEVT_IRQ_EN is defined.
module inevt_wb
    import inevt_pkg::*;
#(
    parameter int unsigned DW     = 32,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N_CH   = 2,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             wb_addr,
    output logic [DW-1:0]          wb_rdata,
    input  logic [DW-1:0]          wb_wdata,
    input  logic                   wb_we,
    input  logic                   wb_cyc,
    output logic                   wb_ack,
    input  logic [N_CH*DATA_W-1:0] ch_data,
    input  logic [N_CH-1:0]        ch_stb,
    output logic                   irq
);

    localparam int unsigned EW = CHID_W + DATA_W;
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [N_CH-1:0]   pend_q, ovf_q, ch_en_q;
    logic [DATA_W-1:0] pend_data_q [N_CH];
    logic [CHID_W-1:0] rr_ptr_q;
    logic              ack_q, pop_q;
    logic [DW-1:0]     rdata_q, rdata_d;

    logic              fifo_wr, fifo_rd, fifo_flush, fifo_empty, fifo_full;
    logic [EW-1:0]     fifo_wdata, fifo_rdata;
    logic [LW-1:0]     fifo_level;

    logic              bus_req, wr_stat, wr_chen;
    logic [N_CH-1:0]   ovf_set, ovf_clr;
    logic              grant_vld;
    logic [CHID_W-1:0] grant_id, arb_idx;
    logic [CHID_W:0]   arb_sum;
    logic [7:0]        req8;
    logic              unused_wdata;

    assign bus_req    = wb_cyc & ~ack_q;
    assign wr_stat    = bus_req & wb_we & (wb_addr == REG_STAT);
    assign wr_chen    = bus_req & wb_we & (wb_addr == REG_CHEN);
    assign fifo_flush = wr_stat & wb_wdata[FLUSH];
    assign fifo_rd    = ack_q & pop_q;
    assign ovf_clr    = wr_stat ? wb_wdata[N_CH-1:0] : '0;
    assign ovf_set    = ch_stb & ch_en_q & pend_q;
    assign unused_wdata = ^wb_wdata;

    // Round-robin search starting at rr_ptr_q; no grant while the FIFO is full.
    always_comb begin
        req8      = 8'(pend_q & ch_en_q);
        grant_vld = 1'b0;
        grant_id  = '0;
        arb_sum   = '0;
        arb_idx   = '0;
        if (!fifo_full) begin
            for (int k = 0; k < N_CH; k++) begin
                arb_sum = {1'b0, rr_ptr_q} + (CHID_W + 1)'(k);
                if (arb_sum >= (CHID_W + 1)'(N_CH)) arb_sum = arb_sum - (CHID_W + 1)'(N_CH);
                arb_idx = arb_sum[CHID_W-1:0];
                if (!grant_vld && req8[arb_idx]) begin
                    grant_vld = 1'b1;
                    grant_id  = arb_idx;
                end
            end
        end
    end

    always_comb begin
        fifo_wdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_id == CHID_W'(i)) fifo_wdata = {grant_id, pend_data_q[i]};
        end
    end
    assign fifo_wr = grant_vld;

    inevt_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (fifo_wr),
        .wdata (fifo_wdata),
        .rd    (fifo_rd),
        .flush (fifo_flush),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= '0;
            ovf_q    <= '0;
            ch_en_q  <= '1;
            rr_ptr_q <= '0;
            for (int i = 0; i < N_CH; i++) pend_data_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (!ch_en_q[i]) begin
                    pend_q[i] <= 1'b0;
                end else begin
                    if (grant_vld && grant_id == CHID_W'(i)) pend_q[i] <= 1'b0;
                    if (ch_stb[i] && !pend_q[i]) begin
                        pend_q[i]      <= 1'b1;
                        pend_data_q[i] <= ch_data[i*DATA_W +: DATA_W];
                    end
                end
            end
            ovf_q <= (ovf_q & ~ovf_clr) | ovf_set;
            if (wr_chen) ch_en_q <= wb_wdata[N_CH-1:0];
            if (grant_vld) begin
                rr_ptr_q <= (grant_id == CHID_W'(N_CH - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

`ifdef INEVT_IRQ_EN
    logic [7:0] thresh_q, thr_eff;
    logic       irq_ena_q, irq_q, wr_irq;

    assign wr_irq  = bus_req & wb_we & (wb_addr == REG_IRQ);
    assign thr_eff = (thresh_q == 8'd0) ? 8'd1 : thresh_q;
    assign irq     = irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thresh_q  <= 8'd1;
            irq_ena_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            if (wr_irq) {irq_ena_q, thresh_q} <= wb_wdata[8:0];
            irq_q <= irq_ena_q & ((9'(fifo_level) >= {1'b0, thr_eff}) | (|ovf_q));
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata_d = '0;
        unique case (wb_addr)
            REG_DATA: begin
                if (fifo_empty) begin
                    rdata_d[EMPTY] = 1'b1;
                end else begin
                    rdata_d[CHID_LSB +: CHID_W] = fifo_rdata[DATA_W +: CHID_W];
                    rdata_d[DATA_W-1:0]         = fifo_rdata[DATA_W-1:0];
                end
            end
            REG_STAT: begin
                rdata_d[EMPTY]         = fifo_empty;
                rdata_d[FULL]          = fifo_full;
                rdata_d[LVL_LSB +: 8]  = sat_level(9'(fifo_level));
                rdata_d[N_CH-1:0]      = ovf_q;
            end
            REG_CHEN: rdata_d[N_CH-1:0] = ch_en_q;
            REG_IRQ: begin
`ifdef INEVT_IRQ_EN
                rdata_d[8:0] = {irq_ena_q, thresh_q};
`endif
            end
        endcase
    end

    // Read data is captured when the request is accepted; the pop lands in the ack cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            pop_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= bus_req;
            pop_q   <= bus_req & ~wb_we & (wb_addr == REG_DATA) & ~fifo_empty;
            rdata_q <= (bus_req & ~wb_we) ? rdata_d : '0;
        end
    end

    assign wb_ack   = ack_q;
    assign wb_rdata = ack_q ? rdata_q : '0;

endmodule

// File: tb/tb_inevt_wb.sv
// Directed self-checking bench for inevt_wb (default parameters, with or without INEVT_IRQ_EN).
module tb_inevt_wb;
    import inevt_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  wb_addr = '0;
    logic [31:0] wb_rdata;
    logic [31:0] wb_wdata = '0;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_ack;
    logic [15:0] ch_data = '0;
    logic [1:0]  ch_stb = '0;
    logic        irq;

    int checks = 0;
    int failures = 0;
    logic [31:0] rv;

    inevt_wb #(.DW(32), .DATA_W(8), .N_CH(2), .DEPTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_addr  (wb_addr),
        .wb_rdata (wb_rdata),
        .wb_wdata (wb_wdata),
        .wb_we    (wb_we),
        .wb_cyc   (wb_cyc),
        .wb_ack   (wb_ack),
        .ch_data  (ch_data),
        .ch_stb   (ch_stb),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge where ack is high.
    task automatic bus(input logic [1:0] a, input logic we, input logic [31:0] wd,
                       output logic [31:0] rd);
        bit got = 0;
        wb_addr = a; wb_we = we; wb_wdata = wd; wb_cyc = 1'b1;
        for (int n = 0; n < 4 && !got; n++) begin
            @(negedge clk);
            if (wb_ack === 1'b1) got = 1;
        end
        if (!got) check("bus_ack_timeout", {31'b0, wb_ack}, 32'h1);
        rd = wb_rdata;
        wb_cyc = 1'b0; wb_we = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        bus(a, 1'b0, 32'h0, d);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus(a, 1'b1, d, dummy);
    endtask

    // One-cycle strobe followed by one idle cycle so a pending word can drain.
    task automatic strobe(input logic [1:0] stb, input logic [7:0] d0, input logic [7:0] d1);
        ch_stb = stb; ch_data = {d1, d0};
        @(negedge clk);
        ch_stb = '0;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", {31'b0, wb_ack}, 32'h0);
        check("rst_rdata", wb_rdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        rd_reg(REG_STAT, rv); check("rst_stat", rv, 32'h8000_0000);
        rd_reg(REG_CHEN, rv); check("rst_chen", rv, 32'h0000_0003);
        rd_reg(REG_IRQ, rv);
`ifdef INEVT_IRQ_EN
        check("rst_irqcfg", rv, 32'h0000_0001);
`else
        check("rst_irqcfg", rv, 32'h0000_0000);
`endif
        @(negedge clk);
        check("rdata_idle_zero", wb_rdata, 32'h0);

        // Single event on ch0
        strobe(2'b01, 8'h41, 8'h00);
        rd_reg(REG_STAT, rv); check("t1_stat", rv, 32'h0001_0000);
        rd_reg(REG_DATA, rv); check("t1_data", rv, 32'h0000_0041);
        rd_reg(REG_DATA, rv); check("t1_empty", rv, 32'h8000_0000);
        wr_reg(REG_DATA, 32'h0000_0055);
        rd_reg(REG_STAT, rv); check("t1_wr_data_ignored", rv, 32'h8000_0000);

        // Simultaneous strobes; pointer sits at ch1 after the ch0 grant
        strobe(2'b11, 8'h10, 8'h20);
        rd_reg(REG_DATA, rv); check("t2_a_first", rv, 32'h0001_0020);
        rd_reg(REG_DATA, rv); check("t2_a_second", rv, 32'h0000_0010);
        strobe(2'b10, 8'h00, 8'h21);
        rd_reg(REG_DATA, rv); check("t2_lone_ch1", rv, 32'h0001_0021);
        strobe(2'b11, 8'h10, 8'h20);
        rd_reg(REG_DATA, rv); check("t2_b_first", rv, 32'h0000_0010);
        rd_reg(REG_DATA, rv); check("t2_b_second", rv, 32'h0001_0020);
        rd_reg(REG_DATA, rv); check("t2_drained", rv, 32'h8000_0000);

        // Fill, overflow, clear
        for (int i = 0; i < 16; i++) strobe(2'b01, 8'h80 + 8'(i), 8'h00);
        strobe(2'b01, 8'hE0, 8'h00);
        strobe(2'b01, 8'hE1, 8'h00);
        rd_reg(REG_STAT, rv); check("t3_full_ovf", rv, 32'h4010_0001);
        wr_reg(REG_STAT, 32'h0000_0001);
        rd_reg(REG_STAT, rv); check("t3_ovf_cleared", rv, 32'h4010_0000);
        rd_reg(REG_DATA, rv); check("t3_head", rv, 32'h0000_0080);
        repeat (3) @(negedge clk);
        rd_reg(REG_STAT, rv); check("t3_pend_refill", rv, 32'h4010_0000);
        for (int i = 1; i < 16; i++) rd_reg(REG_DATA, rv);
        rd_reg(REG_DATA, rv); check("t3_pend_word", rv, 32'h0000_00E0);
        rd_reg(REG_DATA, rv); check("t3_empty_after", rv, 32'h8000_0000);

        // Channel enable mask
        wr_reg(REG_CHEN, 32'h0000_0002);
        rd_reg(REG_CHEN, rv); check("t4_chen", rv, 32'h0000_0002);
        strobe(2'b11, 8'h55, 8'h66);
        rd_reg(REG_STAT, rv); check("t4_stat", rv, 32'h0001_0000);
        rd_reg(REG_DATA, rv); check("t4_data", rv, 32'h0001_0066);

        // Threshold interrupt and flush
        wr_reg(REG_IRQ, 32'h0000_0103);
        rd_reg(REG_IRQ, rv);
`ifdef INEVT_IRQ_EN
        check("t5_irqcfg", rv, 32'h0000_0103);
`else
        check("t5_irqcfg", rv, 32'h0000_0000);
`endif
        strobe(2'b10, 8'h00, 8'h31);
        strobe(2'b10, 8'h00, 8'h32);
        strobe(2'b10, 8'h00, 8'h33);
        check("t5_irq_lag", {31'b0, irq}, 32'h0);
        @(negedge clk);
`ifdef INEVT_IRQ_EN
        check("t5_irq_set", {31'b0, irq}, 32'h1);
`else
        check("t5_irq_tied", {31'b0, irq}, 32'h0);
`endif
        rd_reg(REG_DATA, rv); check("t5_pop", rv, 32'h0001_0031);
        repeat (2) @(negedge clk);
        check("t5_irq_clear", {31'b0, irq}, 32'h0);
        rd_reg(REG_STAT, rv); check("t5_stat", rv, 32'h0002_0000);
        wr_reg(REG_STAT, 32'h8000_0000);
        rd_reg(REG_STAT, rv); check("t5_flushed", rv, 32'h8000_0000);

        // Reset in the middle of an acked read
        for (int i = 0; i < 5; i++) strobe(2'b10, 8'h00, 8'h70 + 8'(i));
        rd_reg(REG_STAT, rv); check("t6_stat5", rv, 32'h0005_0000);
        @(negedge clk);
        rd_reg(REG_DATA, rv); check("t6_pre_rdata", rv, 32'h0001_0070);
        wb_addr = REG_DATA; wb_we = 1'b0; wb_cyc = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t6_ack_before", {31'b0, wb_ack}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("t6_ack_async", {31'b0, wb_ack}, 32'h0);
        check("t6_rdata_async", wb_rdata, 32'h0);
        wb_cyc = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_reg(REG_STAT, rv); check("t6_stat_after", rv, 32'h8000_0000);
        rd_reg(REG_CHEN, rv); check("t6_chen_after", rv, 32'h0000_0003);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
